shared_enc_ctrl: RTL and testbench
==================================

Name: shared_enc_ctrl

Overview:
- Sequencer for the 2-share threshold-implementation uBlock-128/128 encryption core.
- Accepts one shared plaintext per transaction through a valid/ready handshake and registers it.
- Drives the core's enable and round counter, and the key-schedule round index; captures the unmasked-never cipher shares into output registers.
- Sits between the bus/DMA front end and the core plus its shared key schedule.

Parameters:
- NUM_ROUNDS, 16: encryption rounds; final whitening key index equals NUM_ROUNDS; legal range 1..31.
- ROUND_LAT, 2: clock cycles per round (register stages inside the round function); legal range ≥1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext shares valid
- in_ready  out  1  controller can accept a plaintext
- in_plain0  in  128  plaintext share 0
- in_plain1  in  128  plaintext share 1
- abort  in  1  synchronous cancel of the current transaction
- out_valid  out  1  cipher shares valid
- out_ready  in  1  consumer accepts the cipher shares
- out_cipher0  out  128  cipher share 0 (registered)
- out_cipher1  out  128  cipher share 1 (registered)
- busy  out  1  transaction in progress (RUN or CAPTURE)
- enc_ena  out  1  core enable
- enc_round_cnt  out  5  core round counter
- key_round  out  5  key-schedule round index
- core_plain0  out  128  registered plaintext share 0 to core
- core_plain1  out  128  registered plaintext share 1 to core
- core_cipher0  in  128  core cipher share 0
- core_cipher1  in  128  core cipher share 1

Behaviour:
- Reset (clk edge with rst=1): state IDLE, and all outputs 0 (in_ready goes to 1 on the first cycle after reset). Covered registers: plaintext, cipher, round_cnt, sub_cnt.
- FSM states: IDLE, RUN, CAPTURE, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&in_ready: latch in_plain0/1 into core_plain0/1; round_cnt←0; sub_cnt←0; go to RUN.
- RUN
  - enc_ena=1, busy=1; enc_round_cnt=round_cnt; key_round=round_cnt.
  - sub_cnt counts 0..ROUND_LAT-1, so each round value is held exactly ROUND_LAT cycles.
  - At sub_cnt==ROUND_LAT-1: sub_cnt←0 and round_cnt←round_cnt+1.
  - When that increment happens with round_cnt==NUM_ROUNDS-1, go to CAPTURE instead.
- CAPTURE (one cycle)
  - enc_ena=1, busy=1; enc_round_cnt=NUM_ROUNDS-1 (held); key_round=NUM_ROUNDS.
  - At the end of the cycle: out_cipher0/1←core_cipher0/1; out_valid←1; go to DONE.
- DONE
  - out_valid=1, enc_ena=0, busy=0; outputs stable until out_ready.
  - On out_ready: out_valid←0; go to IDLE.
  - in_ready=out_ready in DONE. If in_valid&out_ready in the same cycle, the cipher is retired and the new plaintext is latched in the same edge; go directly to RUN (back-to-back, no idle bubble).
- Latency: accept edge = cycle 0. RUN spans cycles 1..NUM_ROUNDS*ROUND_LAT; CAPTURE is cycle NUM_ROUNDS*ROUND_LAT+1; out_valid is high from cycle NUM_ROUNDS*ROUND_LAT+2 (34 with defaults).
- enc_round_cnt and key_round are 0 outside RUN/CAPTURE.
- Inputs are ignored while in RUN/CAPTURE (in_ready=0).
- abort (any state)
  - Next state IDLE; out_valid←0; core_plain0/1, out_cipher0/1, round_cnt and sub_cnt cleared to 0. No partial share is left in registers.
  - abort has priority over every handshake in the same cycle.
- rst has priority over abort.
- Share separation: share-0 and share-1 paths are never combined (no XOR or mux across shares) inside this block.

Decomposition:
- Shared package ublock_ti_pkg holds:
  - UBLOCK_ROUNDS=16, UBLOCK_ROUND_LAT=2, ROUND_CNT_W=5;
  - the state encoding localparams IDLE=2'd0, RUN=2'd1, CAPTURE=2'd2, DONE=2'd3.
- No sub-module needed; the round/sub-cycle counter pair stays inline.

Test Plan:
- Single transaction with out_ready=1: enc_round_cnt steps 0,0,1,1,…,15,15; key_round=16 on cycle 33; out_valid rises at cycle 34. out_cipher0^out_cipher1 must equal the uBlock-128/128 reference vector for plaintext shares (P^M, M), with M=128'hA5A5…A5.
- Backpressure: out_ready=0 for 10 cycles after out_valid. out_cipher0/1, out_valid=1 and in_ready=0 must stay constant; on the out_ready pulse, out_valid falls the next cycle.
- Back-to-back: in_valid held high with a second plaintext and out_ready=1. The second accept coincides with the first out_valid cycle, and the second out_valid arrives exactly 34 cycles later.
- abort on cycle 17 of a run: next cycle state=IDLE, busy=0, enc_ena=0, and core_plain0/1=0. A following transaction completes correctly with no stale data.
- rst asserted in CAPTURE together with abort and in_valid: all outputs 0 the next cycle, and in_ready=1 the cycle after.
- Parameter sweep NUM_ROUNDS=1/ROUND_LAT=1 and NUM_ROUNDS=31/ROUND_LAT=3: out_valid at cycle NUM_ROUNDS*ROUND_LAT+2 (3 and 95), and enc_round_cnt never exceeds NUM_ROUNDS-1.

Source files
------------

// File: rtl/ublock_ti_pkg.sv
// Shared definitions for the 2-share threshold-implementation uBlock-128/128 core.
// Round/latency defaults, counter width and the sequencer state encoding.
package ublock_ti_pkg;

    localparam int UBLOCK_ROUNDS    = 16;
    localparam int UBLOCK_ROUND_LAT = 2;
    localparam int ROUND_CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } enc_state_t;

    // A one-cycle round still needs a 1-bit sub-cycle counter.
    function automatic int sub_cnt_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/shared_enc_ctrl.sv
// Sequencer for the 2-share TI uBlock-128/128 core: plaintext intake, round
// stepping, key-round indexing and cipher-share capture.
module shared_enc_ctrl
    import ublock_ti_pkg::*;
#(
    parameter int NUM_ROUNDS = UBLOCK_ROUNDS,
    parameter int ROUND_LAT  = UBLOCK_ROUND_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           in_plain0,
    input  logic [127:0]           in_plain1,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           out_cipher0,
    output logic [127:0]           out_cipher1,
    output logic                   busy,
    output logic                   enc_ena,
    output logic [ROUND_CNT_W-1:0] enc_round_cnt,
    output logic [ROUND_CNT_W-1:0] key_round,
    output logic [127:0]           core_plain0,
    output logic [127:0]           core_plain1,
    input  logic [127:0]           core_cipher0,
    input  logic [127:0]           core_cipher1
);

    localparam int SUB_W = sub_cnt_w(ROUND_LAT);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(ROUND_LAT - 1);
    localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
    localparam logic [ROUND_CNT_W-1:0] LAST_RND  = ROUND_CNT_W'(NUM_ROUNDS - 1);
    localparam logic [ROUND_CNT_W-1:0] KEY_FINAL = ROUND_CNT_W'(NUM_ROUNDS);
    localparam logic [ROUND_CNT_W-1:0] RND_ONE   = ROUND_CNT_W'(1);

    enc_state_t             state;
    logic [SUB_W-1:0]       sub_cnt;
    logic [ROUND_CNT_W-1:0] round_cnt;
    logic                   armed;
    logic                   accept;
    logic                   retire;
    logic                   round_end;

    // armed keeps in_ready low for the first cycle out of reset.
    assign in_ready  = armed & ((state == IDLE) |
                                ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign retire    = (state == DONE) & out_ready;
    assign round_end = (sub_cnt == SUB_LAST);

    // round_cnt is zeroed on every exit from CAPTURE, so it can drive the core.
    assign enc_round_cnt = round_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            armed       <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            enc_ena     <= 1'b0;
            round_cnt   <= '0;
            sub_cnt     <= '0;
            key_round   <= '0;
            core_plain0 <= '0;
            core_plain1 <= '0;
            out_cipher0 <= '0;
            out_cipher1 <= '0;
        end else if (abort) begin
            state       <= IDLE;
            armed       <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            enc_ena     <= 1'b0;
            round_cnt   <= '0;
            sub_cnt     <= '0;
            key_round   <= '0;
            core_plain0 <= '0;
            core_plain1 <= '0;
            out_cipher0 <= '0;
            out_cipher1 <= '0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        core_plain0 <= in_plain0;
                        core_plain1 <= in_plain1;
                        round_cnt   <= '0;
                        sub_cnt     <= '0;
                        key_round   <= '0;
                        busy        <= 1'b1;
                        enc_ena     <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (round_end) begin
                        sub_cnt <= '0;
                        if (round_cnt == LAST_RND) begin
                            key_round <= KEY_FINAL;
                            state     <= CAPTURE;
                        end else begin
                            round_cnt <= round_cnt + RND_ONE;
                            key_round <= round_cnt + RND_ONE;
                        end
                    end else begin
                        sub_cnt <= sub_cnt + SUB_ONE;
                    end
                end
                CAPTURE: begin
                    out_cipher0 <= core_cipher0;
                    out_cipher1 <= core_cipher1;
                    out_valid   <= 1'b1;
                    busy        <= 1'b0;
                    enc_ena     <= 1'b0;
                    round_cnt   <= '0;
                    key_round   <= '0;
                    state       <= DONE;
                end
                DONE: begin
                    if (retire) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        // Back-to-back: retire and accept on the same edge.
                        if (accept) begin
                            core_plain0 <= in_plain0;
                            core_plain1 <= in_plain1;
                            round_cnt   <= '0;
                            sub_cnt     <= '0;
                            key_round   <= '0;
                            busy        <= 1'b1;
                            enc_ena     <= 1'b1;
                            state       <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_enc_ctrl.sv
// Directed bench for shared_enc_ctrl with a stand-in core whose cipher shares
// depend on the plaintext shares and on the round/key indices at capture time.
module tb_shared_enc_ctrl;

    localparam logic [127:0] K0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] MASK1 = 128'h20F;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_plain0;
    logic [127:0] in_plain1;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_cipher0;
    logic [127:0] out_cipher1;
    logic         busy;
    logic         enc_ena;
    logic [4:0]   enc_round_cnt;
    logic [4:0]   key_round;
    logic [127:0] core_plain0;
    logic [127:0] core_plain1;
    logic [127:0] core_cipher0;
    logic [127:0] core_cipher1;

    logic         a_in_ready, a_out_valid, a_busy, a_enc_ena;
    logic [127:0] a_oc0, a_oc1, a_cp0, a_cp1;
    logic [4:0]   a_rnd, a_key;
    logic         b_in_ready, b_out_valid, b_busy, b_enc_ena;
    logic [127:0] b_oc0, b_oc1, b_cp0, b_cp1;
    logic [4:0]   b_rnd, b_key;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in core: share 1 picks up the indices present on the capture cycle.
    assign core_cipher0 = core_plain0 ^ K0;
    assign core_cipher1 = core_plain1 ^ {118'd0, key_round, enc_round_cnt};

    shared_enc_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_plain0(in_plain0), .in_plain1(in_plain1),
        .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cipher0(out_cipher0), .out_cipher1(out_cipher1),
        .busy(busy), .enc_ena(enc_ena),
        .enc_round_cnt(enc_round_cnt), .key_round(key_round),
        .core_plain0(core_plain0), .core_plain1(core_plain1),
        .core_cipher0(core_cipher0), .core_cipher1(core_cipher1)
    );

    shared_enc_ctrl #(.NUM_ROUNDS(1), .ROUND_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_plain0(in_plain0), .in_plain1(in_plain1),
        .abort(abort),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_cipher0(a_oc0), .out_cipher1(a_oc1),
        .busy(a_busy), .enc_ena(a_enc_ena),
        .enc_round_cnt(a_rnd), .key_round(a_key),
        .core_plain0(a_cp0), .core_plain1(a_cp1),
        .core_cipher0(a_cp0), .core_cipher1(a_cp1)
    );

    shared_enc_ctrl #(.NUM_ROUNDS(31), .ROUND_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_plain0(in_plain0), .in_plain1(in_plain1),
        .abort(abort),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_cipher0(b_oc0), .out_cipher1(b_oc1),
        .busy(b_busy), .enc_ena(b_enc_ena),
        .enc_round_cnt(b_rnd), .key_round(b_key),
        .core_plain0(b_cp0), .core_plain1(b_cp1),
        .core_cipher0(b_cp0), .core_cipher1(b_cp1)
    );

    typedef struct {
        logic [127:0] p;
        logic [127:0] m;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept at edge 0, then return once out_valid is seen (cycle = k+1).
    task automatic do_txn(input logic [127:0] p0, input logic [127:0] p1,
                          input bit trace, output int cyc);
        int k;
        in_plain0 = p0;
        in_plain1 = p1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 200) begin
            if (trace) begin
                chk("round_cnt", 128'(enc_round_cnt),
                    (k < 32) ? 128'(k / 2) : 128'd15);
                chk("key_round", 128'(key_round),
                    (k < 32) ? 128'(k / 2) : 128'd16);
            end
            step();
            k++;
        end
        cyc = k + 1;
    endtask

    initial begin
        int cyc;
        int a_cyc;
        int b_cyc;
        int a_max;
        int b_max;
        int n;

        vecs[0] = '{128'h0, {16{8'hA5}},
                    128'h0F0E0D0C_0B0A0908_07060504_0302030F};
        vecs[1] = '{{128{1'b1}}, 128'h0,
                    128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFCF0};
        vecs[2] = '{128'h01234567_89ABCDEF_FEDCBA98_76543210, {16{8'hA5}},
                    128'h0E2D486B_82A1C4E7_F9DABF9C_7556311F};
        vecs[3] = '{128'h80000000_00000000_00000000_00000001, {16{8'h5A}},
                    128'h8F0E0D0C_0B0A0908_07060504_0302030E};

        rst = 1'b1;
        abort = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_plain0 = '0;
        in_plain1 = '0;
        step();
        step();
        chk("rst out_valid", 128'(out_valid), 128'd0);
        chk("rst in_ready", 128'(in_ready), 128'd0);
        chk("rst busy", 128'({busy, enc_ena}), 128'd0);
        chk("rst rounds", 128'({enc_round_cnt, key_round}), 128'd0);
        chk("rst core_plain0", core_plain0, 128'd0);
        chk("rst out_cipher1", out_cipher1, 128'd0);
        rst = 1'b0;
        step();
        chk("post-rst in_ready", 128'(in_ready), 128'd1);

        foreach (vecs[i]) begin
            do_txn(vecs[i].p ^ vecs[i].m, vecs[i].m, i == 0, cyc);
            chk("latency", 128'(cyc), 128'd34);
            chk("cipher xor", out_cipher0 ^ out_cipher1, vecs[i].exp);
            chk("cipher share1", out_cipher1, vecs[i].m ^ MASK1);
            chk("done busy", 128'({busy, enc_ena}), 128'd0);
            step();
            chk("retired", 128'(out_valid), 128'd0);
        end

        // Backpressure: hold DONE for 10 cycles.
        out_ready = 1'b0;
        do_txn(vecs[2].p ^ vecs[2].m, vecs[2].m, 1'b0, cyc);
        chk("bp latency", 128'(cyc), 128'd34);
        n = 0;
        repeat (10) begin
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                (out_cipher0 ^ out_cipher1) !== vecs[2].exp)
                n++;
        end
        chk("bp stable cycles bad", 128'(n), 128'd0);
        out_ready = 1'b1;
        step();
        chk("bp release", 128'(out_valid), 128'd0);

        // Back-to-back with in_valid held high.
        do_txn(vecs[0].p ^ vecs[0].m, vecs[0].m, 1'b0, cyc);
        chk("b2b first latency", 128'(cyc), 128'd34);
        in_plain0 = vecs[3].p ^ vecs[3].m;
        in_plain1 = vecs[3].m;
        in_valid  = 1'b1;
        #1;
        chk("b2b in_ready", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        chk("b2b accepted", core_plain1, vecs[3].m);
        chk("b2b busy", 128'({busy, out_valid}), 128'b10);
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("b2b spacing", 128'(n), 128'd34);
        chk("b2b cipher", out_cipher0 ^ out_cipher1, vecs[3].exp);
        step();

        // Abort sampled on edge 17.
        in_plain0 = vecs[1].p ^ vecs[1].m;
        in_plain1 = vecs[1].m;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (16) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort busy", 128'({busy, enc_ena, out_valid}), 128'd0);
        chk("abort plain0", core_plain0, 128'd0);
        chk("abort plain1", core_plain1, 128'd0);
        chk("abort cipher", out_cipher0, 128'd0);
        chk("abort rounds", 128'({enc_round_cnt, key_round}), 128'd0);
        chk("abort in_ready", 128'(in_ready), 128'd1);
        do_txn(vecs[2].p ^ vecs[2].m, vecs[2].m, 1'b0, cyc);
        chk("after abort latency", 128'(cyc), 128'd34);
        chk("after abort cipher", out_cipher0 ^ out_cipher1, vecs[2].exp);
        step();

        // rst together with abort and in_valid while in CAPTURE.
        in_plain0 = vecs[0].p;
        in_plain1 = vecs[0].m;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (32) step();
        chk("capture key", 128'(key_round), 128'd16);
        rst = 1'b1;
        abort = 1'b1;
        in_valid = 1'b1;
        step();
        chk("rstcap ctl", 128'({in_ready, out_valid, busy, enc_ena}), 128'd0);
        chk("rstcap rounds", 128'({enc_round_cnt, key_round}), 128'd0);
        chk("rstcap plain", core_plain0 | core_plain1, 128'd0);
        chk("rstcap cipher", out_cipher0 | out_cipher1, 128'd0);
        rst = 1'b0;
        abort = 1'b0;
        step();
        chk("rstcap in_ready", 128'(in_ready), 128'd1);
        chk("rstcap no accept", 128'(busy), 128'd0);
        in_valid = 1'b0;

        // Parameter sweep instances, accepted together after a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        out_ready = 1'b0;
        in_plain0 = 128'h1;
        in_plain1 = 128'h2;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        a_cyc = -1;
        b_cyc = -1;
        a_max = 0;
        b_max = 0;
        for (int k = 0; k < 120; k++) begin
            if (int'(a_rnd) > a_max) a_max = int'(a_rnd);
            if (int'(b_rnd) > b_max) b_max = int'(b_rnd);
            if (a_out_valid === 1'b1 && a_cyc < 0) a_cyc = k + 1;
            if (b_out_valid === 1'b1 && b_cyc < 0) b_cyc = k + 1;
            step();
        end
        chk("sweep1 latency", 128'(a_cyc), 128'd3);
        chk("sweep31 latency", 128'(b_cyc), 128'd95);
        chk("sweep1 max round", 128'(a_max), 128'd0);
        chk("sweep31 max round", 128'(b_max), 128'd30);
        chk("sweep31 cipher", b_oc0 ^ b_oc1, 128'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
